// File: rtl/valve_seq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : valve_seq_pkg                                              |
// | Description : Shared state encoding, safe level, field positions and     |
// |               defaults for the valve step sequencer.                     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package valve_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_HOLD = 3'd2,
        ST_NEXT = 3'd3,
        ST_DONE = 3'd4
    } seq_state_t;

    // Level driven whenever playback is aborted.
    localparam logic SAFE_LEVEL = 1'b0;

    localparam int DEF_HOLD_W   = 16;
    localparam int DEF_TICK_DIV = 100000;

    // The valve level sits just above the hold-tick field in a table word.
    function automatic int level_bit(input int hold_w);
        return hold_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/valve_step_sequencer_tick_prescaler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tick_prescaler                                             |
// | Description : Divides enabled clk cycles into a one-cycle tick pulse     |
// |               every TICK_DIV enabled cycles.                             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tick_prescaler
    import valve_seq_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic clk,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int             CNT_W  = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] c_last = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] c_one  = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;

    // Count enabled cycles 0..TICK_DIV-1, wrapping back to zero.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= (r_cnt == c_last) ? '0 : r_cnt + c_one;
        end
    end

    assign tick = en && (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/valve_step_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : valve_step_sequencer                                       |
// | Description : Plays back a programmed table of valve steps (level +      |
// |               hold time) towards the servo PWM interface.               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module valve_step_sequencer
    import valve_seq_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int ADDR_W   = 4,
    parameter int HOLD_W   = DEF_HOLD_W,
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [HOLD_W:0]   wr_data,
    input  logic [ADDR_W:0]   num_steps,
    input  logic              loop_en,
    input  logic              start,
    input  logic              abort,
    output logic              set_bit,
    output logic              delay_start,
    output logic              count_done,
    output logic              busy,
    output logic [ADDR_W-1:0] step_idx,
    output logic              seq_done
);

    localparam int                LEVEL_BIT  = level_bit(HOLD_W);
    localparam logic [ADDR_W:0]   c_depth    = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   c_n_one    = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] c_step_one = ADDR_W'(1);
    localparam logic [HOLD_W-1:0] c_hold_one = HOLD_W'(1);

    seq_state_t        r_state, w_state_nxt;
    logic [HOLD_W:0]   r_table [DEPTH];
    logic [ADDR_W:0]   r_n, w_n_nxt;
    logic [HOLD_W-1:0] r_remaining, w_rem_nxt;
    logic [ADDR_W-1:0] r_step_idx, w_step_nxt;
    logic              r_set_bit, w_set_bit_nxt;
    logic              r_delay_start, r_count_done, r_busy, r_seq_done;

    logic [HOLD_W:0]   w_entry;
    logic [ADDR_W:0]   w_last_idx;
    logic              w_wr_ok;
    logic              w_tick;

    assign w_entry    = r_table[r_step_idx];
    assign w_last_idx = r_n - c_n_one;
    assign w_wr_ok    = wr_en && !clr && !abort && (r_state == ST_IDLE) &&
                        ({1'b0, wr_addr} < c_depth);

    // Prescaler restarts at the top of every step and only runs during HOLD.
    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_prescaler (
        .clk  (clk),
        .clr  (clr || (r_state == ST_LOAD)),
        .en   (r_state == ST_HOLD),
        .tick (w_tick)
    );

    // Step table: plain storage, deliberately untouched by reset.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_table[wr_addr] <= wr_data;
        end
    end

    // Next-state and next-output decode; abort overrides every state.
    always_comb begin
        w_state_nxt   = r_state;
        w_n_nxt       = r_n;
        w_rem_nxt     = r_remaining;
        w_step_nxt    = r_step_idx;
        w_set_bit_nxt = r_set_bit;
        if (abort) begin
            w_state_nxt   = ST_IDLE;
            w_set_bit_nxt = SAFE_LEVEL;
            w_step_nxt    = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (num_steps == '0) begin
                            w_state_nxt = ST_DONE;
                        end else begin
                            w_n_nxt     = (num_steps > c_depth) ? c_depth : num_steps;
                            w_step_nxt  = '0;
                            w_state_nxt = ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    w_set_bit_nxt = w_entry[LEVEL_BIT];
                    w_rem_nxt     = w_entry[HOLD_W-1:0];
                    w_state_nxt   = ST_HOLD;
                end
                ST_HOLD: begin
                    // Leaving on the tick that would bring remaining to zero
                    // makes a hold of H last exactly H*TICK_DIV cycles.
                    if (w_tick && (r_remaining != '0)) begin
                        w_rem_nxt = r_remaining - c_hold_one;
                    end
                    if ((r_remaining == '0) || (w_tick && (r_remaining == c_hold_one))) begin
                        w_state_nxt = ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    if ({1'b0, r_step_idx} == w_last_idx) begin
                        if (loop_en) begin
                            w_step_nxt  = '0;
                            w_state_nxt = ST_LOAD;
                        end else begin
                            w_state_nxt = ST_DONE;
                        end
                    end else begin
                        w_step_nxt  = r_step_idx + c_step_one;
                        w_state_nxt = ST_LOAD;
                    end
                end
                ST_DONE: begin
                    w_state_nxt = ST_IDLE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State, datapath and registered outputs; outputs track the next state.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state       <= ST_IDLE;
            r_n           <= '0;
            r_remaining   <= '0;
            r_step_idx    <= '0;
            r_set_bit     <= 1'b0;
            r_delay_start <= 1'b0;
            r_count_done  <= 1'b0;
            r_busy        <= 1'b0;
            r_seq_done    <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_n           <= w_n_nxt;
            r_remaining   <= w_rem_nxt;
            r_step_idx    <= w_step_nxt;
            r_set_bit     <= w_set_bit_nxt;
            r_delay_start <= (w_state_nxt == ST_HOLD);
            r_count_done  <= (w_state_nxt == ST_NEXT);
            r_busy        <= (w_state_nxt != ST_IDLE);
            r_seq_done    <= (w_state_nxt == ST_DONE);
        end
    end

    assign set_bit     = r_set_bit;
    assign delay_start = r_delay_start;
    assign count_done  = r_count_done;
    assign busy        = r_busy;
    assign step_idx    = r_step_idx;
    assign seq_done    = r_seq_done;

endmodule
`default_nettype wire
